// File: rtl/ifetch.sv
// Instruction fetch: PC, single-outstanding imem req/ack, two-entry in-order buffer.
// IFETCH_MISALIGN_CHK_EN: trap misaligned redirects into FAULT instead of masking them.
module ifetch #(
  parameter int              BITS     = 32,
  parameter logic [BITS-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [BITS-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [BITS-1:0] redirect_pc,
  output logic [31:0]     instr,
  output logic [BITS-1:0] instr_pc,
  output logic            instr_valid,
  output logic            fetch_fault
);

  // state  | meaning
  // IDLE   | out of reset, request issues at the first edge
  // FETCH  | request outstanding
  // FULL   | both entries occupied, no request
  // DRAIN  | outstanding request after a redirect, data to be discarded
  // FAULT  | misaligned redirect trapped (macro builds only)
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FULL,
    S_DRAIN
`ifdef IFETCH_MISALIGN_CHK_EN
    , S_FAULT
`endif
  } state_t;

  localparam logic [31:0]     NOP      = 32'h0000_0013;
  localparam logic [BITS-1:0] PC_MASK  = {{(BITS-2){1'b1}}, 2'b00};
  localparam logic [BITS-1:0] START_PC = RESET_PC & PC_MASK;
  localparam logic [BITS-1:0] FOUR     = BITS'(4);

  state_t          state;
  logic [BITS-1:0] pc;
  logic [31:0]     skid_instr;
  logic [BITS-1:0] skid_pc;
  logic            skid_valid;

  logic            consume;
  logic [1:0]      count;
  logic [1:0]      count_next;
  logic [BITS-1:0] pc_plus4;
  logic [BITS-1:0] target;

  assign consume    = instr_valid && !stall;
  assign count      = {1'b0, instr_valid} + {1'b0, skid_valid};
  assign count_next = count + 2'd1 - {1'b0, consume};
  assign pc_plus4   = pc + FOUR;

`ifdef IFETCH_MISALIGN_CHK_EN
  logic misalign;
  logic drain_fault;
  assign misalign = |redirect_pc[1:0];
  assign target   = redirect_pc;
`else
  assign target      = redirect_pc & PC_MASK;
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= START_PC;
      imem_req    <= 1'b0;
      imem_addr   <= START_PC;
      instr       <= NOP;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      skid_instr  <= NOP;
      skid_pc     <= '0;
      skid_valid  <= 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
      fetch_fault <= 1'b0;
      drain_fault <= 1'b0;
`endif
    end else if (redirect) begin
      instr_valid <= 1'b0;
      skid_valid  <= 1'b0;
      pc          <= target;
`ifdef IFETCH_MISALIGN_CHK_EN
      fetch_fault <= misalign;
      drain_fault <= misalign;
`endif
      // an unacknowledged request must still complete before anything new issues
      if (imem_req && !imem_ack) begin
        state <= S_DRAIN;
      end
`ifdef IFETCH_MISALIGN_CHK_EN
      else if (misalign) begin
        state    <= S_FAULT;
        imem_req <= 1'b0;
      end
`endif
      else begin
        state     <= S_FETCH;
        imem_req  <= 1'b1;
        imem_addr <= target;
      end
    end else begin
      case (state)
        S_IDLE: begin
          state     <= S_FETCH;
          imem_req  <= 1'b1;
          imem_addr <= pc;
        end
        S_FETCH: begin
          if (imem_ack) begin
            pc        <= pc_plus4;
            imem_addr <= pc_plus4;
            if (consume && skid_valid) begin
              instr      <= skid_instr;
              instr_pc   <= skid_pc;
              skid_instr <= imem_rdata;
              skid_pc    <= imem_addr;
            end else if (consume || !instr_valid) begin
              instr       <= imem_rdata;
              instr_pc    <= imem_addr;
              instr_valid <= 1'b1;
            end else begin
              skid_instr <= imem_rdata;
              skid_pc    <= imem_addr;
              skid_valid <= 1'b1;
            end
            if (count_next >= 2'd2) begin
              imem_req <= 1'b0;
              state    <= S_FULL;
            end
          end else if (consume) begin
            if (skid_valid) begin
              instr      <= skid_instr;
              instr_pc   <= skid_pc;
              skid_valid <= 1'b0;
            end else begin
              instr_valid <= 1'b0;
            end
          end
        end
        S_FULL: begin
          if (consume) begin
            instr      <= skid_instr;
            instr_pc   <= skid_pc;
            skid_valid <= 1'b0;
            state      <= S_FETCH;
            imem_req   <= 1'b1;
            imem_addr  <= pc;
          end
        end
        S_DRAIN: begin
          if (imem_ack) begin
`ifdef IFETCH_MISALIGN_CHK_EN
            if (drain_fault) begin
              state    <= S_FAULT;
              imem_req <= 1'b0;
            end else
`endif
            begin
              state     <= S_FETCH;
              imem_addr <= pc;
            end
          end
        end
`ifdef IFETCH_MISALIGN_CHK_EN
        S_FAULT: begin
          state <= S_FAULT;
        end
`endif
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios plus randomized stall/ack/redirect
// traffic, checked against an occupancy/program-order reference model.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        fetch_fault;

  ifetch #(.BITS(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  // reference model: buffered entries, next expected consumed/requested PC
  int          occ;
  logic [31:0] exp_cons_pc;
  logic [31:0] exp_req_addr;
  bit          discard;
  bit          prev_pending;
  logic [31:0] prev_addr;
  bit          fault_exp;
  bit          faulted;
  int          wait_cnt;
  int          cur_delay;
  bit          rand_delay;
  int          n_complete;

  task automatic model_reset();
    occ          = 0;
    exp_cons_pc  = 32'h0;
    exp_req_addr = 32'h0;
    discard      = 1'b0;
    prev_pending = 1'b0;
    prev_addr    = 32'h0;
    fault_exp    = 1'b0;
    faulted      = 1'b0;
    wait_cnt     = 0;
  endtask

  // called at a negedge: check current outputs, drive inputs for the next edge, advance model
  task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc);
    bit          complete;
    bit          consume;
    bit          misal;
    logic [31:0] tgt;
    check_val("valid_vs_occ", instr_valid, occ > 0);
    check_val("fault_flag", fetch_fault, fault_exp);
    if (occ >= 2) check_val("full_no_req", imem_req, 0);
    if (imem_req) begin
      check_val("addr_align", imem_addr[1:0], 0);
      if (!discard) check_val("req_addr", imem_addr, exp_req_addr);
    end
    if (faulted && !discard) check_val("fault_no_req", imem_req, 0);
    if (prev_pending) begin
      check_val("req_hold", imem_req, 1);
      check_val("addr_hold", imem_addr, prev_addr);
    end

    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_rdata  = mem_word(imem_addr);
    imem_ack    = imem_req ? (wait_cnt >= cur_delay) : 1'($urandom_range(0, 1));

    complete = imem_req && imem_ack;
    consume  = instr_valid && !st;
    if (consume) begin
      check_val("cons_pc", instr_pc, exp_cons_pc);
      check_val("cons_instr", instr, mem_word(exp_cons_pc));
      exp_cons_pc += 32'd4;
      occ--;
    end
    if (complete) n_complete++;
    if (rd) begin
`ifdef IFETCH_MISALIGN_CHK_EN
      misal = (rpc[1:0] != 2'b00);
      tgt   = rpc;
`else
      misal = 1'b0;
      tgt   = rpc & ~32'h3;
`endif
      occ       = 0;
      discard   = imem_req && !imem_ack;
      fault_exp = misal;
      faulted   = misal;
      if (!misal) begin
        exp_req_addr = tgt;
        exp_cons_pc  = tgt;
      end
    end else if (complete) begin
      if (discard) discard = 1'b0;
      else begin
        occ++;
        exp_req_addr += 32'd4;
      end
    end
    prev_pending = imem_req && !imem_ack;
    prev_addr    = imem_addr;
    if (complete || !imem_req) begin
      wait_cnt = 0;
      if (rand_delay) cur_delay = $urandom_range(0, 3);
    end else begin
      wait_cnt++;
    end
  endtask

  task automatic run(input int n, input bit st);
    repeat (n) begin
      @(negedge clk);
      cycle(st, 1'b0, 32'h0);
    end
  endtask

  initial begin
    logic [31:0] held;
    bit          found;
    int          c0;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    cur_delay = 0; rand_delay = 1'b0; n_complete = 0;
    model_reset();

    repeat (2) @(negedge clk);
    check_val("rst_req", imem_req, 0);
    check_val("rst_addr", imem_addr, 32'h0);
    check_val("rst_instr", instr, 32'h13);
    check_val("rst_pc", instr_pc, 32'h0);
    check_val("rst_valid", instr_valid, 0);
    check_val("rst_fault", fetch_fault, 0);
    rst = 1'b0;
    cycle(1'b0, 1'b0, 32'h0);

    // streaming, ack tied high
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      check_val("stream_addr", imem_addr, 32'(4 * (n - 1)));
      if (n >= 2) check_val("stream_valid", instr_valid, 1);
      cycle(1'b0, 1'b0, 32'h0);
    end

    // decode back-pressure for 5 cycles
    held = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) held = instr;
      else check_val("stall_hold", instr, held);
      cycle(1'b1, 1'b0, 32'h0);
    end
    @(negedge clk);
    check_val("stall_req_drop", imem_req, 0);
    cycle(1'b0, 1'b0, 32'h0);
    run(10, 1'b0);

    // 3-cycle ack delay
    cur_delay = 3;
    run(8, 1'b0);
    c0 = n_complete;
    run(40, 1'b0);
    check_val("delay3_rate", n_complete - c0, 10);

    // redirect while 0x20 is pending without ack
    cur_delay = 0;
    @(negedge clk);
    cycle(1'b0, 1'b1, 32'h0);
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 32'h20) begin
        found = 1'b1;
        break;
      end
      cycle(1'b0, 1'b0, 32'h0);
    end
    check_val("find_0x20", found, 1);
    cur_delay = 255;
    cycle(1'b0, 1'b1, 32'h100);
    @(negedge clk);
    check_val("drain_req", imem_req, 1);
    check_val("drain_addr", imem_addr, 32'h20);
    check_val("drain_valid", instr_valid, 0);
    cycle(1'b0, 1'b0, 32'h0);
    cur_delay = 2;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (imem_addr != 32'h20) break;
      cycle(1'b0, 1'b0, 32'h0);
    end
    check_val("drain_next_addr", imem_addr, 32'h100);
    cycle(1'b0, 1'b0, 32'h0);
    run(16, 1'b0);

    // redirect together with ack and consumption
    cur_delay = 0;
    run(4, 1'b0);
    @(negedge clk);
    check_val("rac_pre_valid", instr_valid, 1);
    check_val("rac_pre_req", imem_req, 1);
    cycle(1'b0, 1'b1, 32'h300);
    @(negedge clk);
    check_val("rac_valid", instr_valid, 0);
    check_val("rac_req", imem_req, 1);
    check_val("rac_addr", imem_addr, 32'h300);
    cycle(1'b0, 1'b0, 32'h0);
    run(6, 1'b0);

    // misaligned redirect
`ifdef IFETCH_MISALIGN_CHK_EN
    cur_delay = 2;
    run(3, 1'b0);
    @(negedge clk);
    cycle(1'b0, 1'b1, 32'h102);
    @(negedge clk);
    check_val("mis_fault_set", fetch_fault, 1);
    cycle(1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!imem_req) break;
      cycle(1'b0, 1'b0, 32'h0);
    end
    check_val("mis_req_off", imem_req, 0);
    cycle(1'b0, 1'b0, 32'h0);
    run(6, 1'b0);
    @(negedge clk);
    cycle(1'b0, 1'b1, 32'h200);
    @(negedge clk);
    check_val("mis_fault_clr", fetch_fault, 0);
    check_val("mis_resume_addr", imem_addr, 32'h200);
    check_val("mis_resume_req", imem_req, 1);
    cycle(1'b0, 1'b0, 32'h0);
    run(10, 1'b0);
`else
    @(negedge clk);
    cycle(1'b0, 1'b1, 32'h102);
    @(negedge clk);
    check_val("mis_mask_addr", imem_addr, 32'h100);
    check_val("mis_no_fault", fetch_fault, 0);
    cycle(1'b0, 1'b0, 32'h0);
    run(10, 1'b0);
`endif

    // PC wrap-around
    cur_delay = 0;
    @(negedge clk);
    cycle(1'b0, 1'b1, 32'hFFFF_FFF0);
    run(4, 1'b0);
    @(negedge clk);
    check_val("wrap_addr", imem_addr, 32'h0000_0000);
    cycle(1'b0, 1'b0, 32'h0);
    run(6, 1'b0);

    // randomized traffic
    rand_delay = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 40) == 0),
            32'($urandom_range(0, 4095)));
    end
    @(negedge clk);
    cycle(1'b0, 1'b1, 32'h400);
    run(20, 1'b0);

    // reset in the middle of a transaction
    rand_delay = 1'b0;
    cur_delay  = 3;
    run(2, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rstm_req", imem_req, 0);
    check_val("rstm_addr", imem_addr, 32'h0);
    check_val("rstm_valid", instr_valid, 0);
    check_val("rstm_instr", instr, 32'h13);
    check_val("rstm_fault", fetch_fault, 0);
    model_reset();
    cur_delay = 0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 1'b0, 32'h0);
    run(12, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
